// File: rtl/uart_fifo_core.sv
// +----------------------------------------------------------------------------+
// | uart_fifo_core : single-clock UART TX/RX engines with TX and RX FIFOs,      |
// |                  baud clock-enables and sticky receive error flags.         |
// | Option macro   : UART_LOOPBACK_EN (adds the internal loopback input)        |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  // Extra pointer bit separates the full and empty cases when the indices match.
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr && !full) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr && !full) wptr <= wptr + 1'b1;
      if (rd && !empty) rptr <= rptr + 1'b1;
    end
  end
endmodule

module uart_fifo_core #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int OVS        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  div_tx,
  input  logic [DIV_W-1:0]  div_rx,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
  input  logic              tx_en,
  input  logic              rx_en,
  input  logic              tx_wr,
  input  logic [DATA_W-1:0] tx_wdata,
  output logic              tx_full,
  output logic              tx_busy,
  input  logic              rx_rd,
  output logic [DATA_W-1:0] rx_rdata,
  output logic              rx_empty,
  input  logic              err_clr,
  output logic              rx_overrun,
  output logic              rx_frame_err,
  output logic              rx_par_err,
  input  logic              rx,
`ifdef UART_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              tx
);
  localparam int OW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W);
  localparam logic [OW-1:0] OS_HALF  = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] OS_LAST  = OW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic              tx_line;
  logic              rx_src;
  logic              tx_empty;
  logic [DATA_W-1:0] tx_head;
  logic              tx_pop;
  logic              tx_tick;
  state_t            tx_state;
  logic [DIV_W-1:0]  tx_cnt;
  logic [DATA_W-1:0] tx_shreg;
  logic [BW-1:0]     tx_bitcnt;
  logic              tx_par;
  logic              tx_stop2;

  uart_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .wr(tx_wr), .wdata(tx_wdata), .rd(tx_pop),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  assign tx_tick = (tx_state != S_IDLE) && (tx_cnt == div_tx);
  assign tx_busy = (tx_state != S_IDLE);
  // A new frame is loaded from IDLE or straight out of the final stop period.
  assign tx_pop  = tx_en && !tx_empty &&
                   ((tx_state == S_IDLE) ||
                    ((tx_state == S_STOP) && tx_tick && (!two_stop || tx_stop2)));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= S_IDLE;
      tx_line   <= 1'b1;
      tx_cnt    <= '0;
      tx_shreg  <= '0;
      tx_bitcnt <= '0;
      tx_par    <= 1'b0;
      tx_stop2  <= 1'b0;
    end else begin
      tx_cnt <= ((tx_state == S_IDLE) || tx_tick) ? '0 : tx_cnt + 1'b1;
      if (tx_pop) begin
        tx_shreg <= tx_head;
        tx_par   <= (^tx_head) ^ parity_odd;
        tx_line  <= 1'b0;
        tx_state <= S_START;
      end else begin
        case (tx_state)
          S_IDLE: tx_line <= 1'b1;
          S_START: if (tx_tick) begin
            tx_line   <= tx_shreg[0];
            tx_shreg  <= tx_shreg >> 1;
            tx_bitcnt <= '0;
            tx_state  <= S_DATA;
          end
          S_DATA: if (tx_tick) begin
            if (tx_bitcnt == BIT_LAST) begin
              tx_line  <= parity_en ? tx_par : 1'b1;
              tx_stop2 <= 1'b0;
              tx_state <= parity_en ? S_PARITY : S_STOP;
            end else begin
              tx_line   <= tx_shreg[0];
              tx_shreg  <= tx_shreg >> 1;
              tx_bitcnt <= tx_bitcnt + 1'b1;
            end
          end
          S_PARITY: if (tx_tick) begin
            tx_line  <= 1'b1;
            tx_stop2 <= 1'b0;
            tx_state <= S_STOP;
          end
          S_STOP: if (tx_tick) begin
            if (two_stop && !tx_stop2) tx_stop2 <= 1'b1;
            else                       tx_state <= S_IDLE;
          end
          default: tx_state <= S_IDLE;
        endcase
      end
    end
  end

  logic              rx_s1;
  logic              rx_s2;
  logic              rx_prev;
  state_t            rx_state;
  logic [DIV_W-1:0]  rx_cnt;
  logic [OW-1:0]     rx_os;
  logic [BW-1:0]     rx_bitcnt;
  logic [DATA_W-1:0] rx_shreg;
  logic              rx_par_bad;
  logic              rx_tick;
  logic              rx_push;
  logic              rx_full;
  logic [DATA_W-1:0] rx_head;

  assign rx_tick = (rx_state != S_IDLE) && (rx_cnt == div_rx);
  assign rx_push = (rx_state == S_STOP) && rx_tick && (rx_os == OS_LAST);

  uart_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .wr(rx_push), .wdata(rx_shreg), .rd(rx_rd),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  assign rx_rdata = rx_empty ? '0 : rx_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_os      <= '0;
      rx_bitcnt  <= '0;
      rx_shreg   <= '0;
      rx_par_bad <= 1'b0;
    end else begin
      rx_s1   <= rx_src;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_cnt  <= ((rx_state == S_IDLE) || rx_tick) ? '0 : rx_cnt + 1'b1;
      case (rx_state)
        S_IDLE: begin
          rx_os      <= '0;
          rx_par_bad <= 1'b0;
          if (rx_en && rx_prev && !rx_s2) rx_state <= S_START;
        end
        S_START: if (rx_tick) begin
          if (rx_os == OS_HALF) begin
            rx_os     <= '0;
            rx_bitcnt <= '0;
            rx_state  <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_os <= rx_os + 1'b1;
          end
        end
        S_DATA: if (rx_tick) begin
          if (rx_os == OS_LAST) begin
            rx_os    <= '0;
            rx_shreg <= {rx_s2, rx_shreg[DATA_W-1:1]};
            if (rx_bitcnt == BIT_LAST) rx_state <= parity_en ? S_PARITY : S_STOP;
            else                       rx_bitcnt <= rx_bitcnt + 1'b1;
          end else begin
            rx_os <= rx_os + 1'b1;
          end
        end
        S_PARITY: if (rx_tick) begin
          if (rx_os == OS_LAST) begin
            rx_os      <= '0;
            rx_par_bad <= rx_s2 ^ (^rx_shreg) ^ parity_odd;
            rx_state   <= S_STOP;
          end else begin
            rx_os <= rx_os + 1'b1;
          end
        end
        S_STOP: if (rx_tick) begin
          if (rx_os == OS_LAST) rx_state <= S_IDLE;
          else                  rx_os    <= rx_os + 1'b1;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_par_err   <= 1'b0;
    end else begin
      if (rx_push && rx_full)          rx_overrun <= 1'b1;
      else if (err_clr)                rx_overrun <= 1'b0;
      if (rx_push && !rx_s2)           rx_frame_err <= 1'b1;
      else if (err_clr)                rx_frame_err <= 1'b0;
      if (rx_push && parity_en && rx_par_bad) rx_par_err <= 1'b1;
      else if (err_clr)                rx_par_err <= 1'b0;
    end
  end

`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_line : rx;
  assign tx     = loopback ? 1'b1 : tx_line;
`else
  assign rx_src = rx;
  assign tx     = tx_line;
`endif
endmodule

`default_nettype wire

// File: tb/tb_uart_fifo_core.sv
// +----------------------------------------------------------------------------+
// | tb_uart_fifo_core : scoreboard bench with serial TX decoder, RX frame       |
// |                     generator and FIFO-drain monitor.                       |
// | Revision          : 1.0                                                     |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_uart_fifo_core;
  localparam int DATA_W = 8, FIFO_DEPTH = 8, DIV_W = 16, OVS = 16;

  logic clk = 1'b0;
  logic rst;
  logic [DIV_W-1:0] div_tx, div_rx;
  logic parity_en, parity_odd, two_stop, tx_en, rx_en;
  logic tx_wr, rx_rd, err_clr;
  logic [DATA_W-1:0] tx_wdata;
  logic tx_full, tx_busy, rx_empty, rx_overrun, rx_frame_err, rx_par_err, tx;
  logic [DATA_W-1:0] rx_rdata;
  logic rx_drv, ext_loop;
  logic rx_pad;

  assign rx_pad = ext_loop ? tx : rx_drv;

  uart_fifo_core #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W), .OVS(OVS)) dut (
    .clk(clk), .rst(rst), .div_tx(div_tx), .div_rx(div_rx),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .tx_en(tx_en), .rx_en(rx_en), .tx_wr(tx_wr), .tx_wdata(tx_wdata),
    .tx_full(tx_full), .tx_busy(tx_busy), .rx_rd(rx_rd), .rx_rdata(rx_rdata),
    .rx_empty(rx_empty), .err_clr(err_clr), .rx_overrun(rx_overrun),
    .rx_frame_err(rx_frame_err), .rx_par_err(rx_par_err), .rx(rx_pad),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .tx(tx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  bit tx_mon_en = 1'b1;
  bit rx_mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit par_of(input logic [7:0] d, input bit odd);
    return (^d) ^ odd;
  endfunction

  // Serial decoder for the tx pad: samples the middle of every bit.
  initial begin : tx_monitor
    int p;
    logic [7:0] d;
    bit pb, sb1, sb2, st;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_mon_en && tx === 1'b0) begin
        p = int'(div_tx) + 1;
        sb2 = 1'b1;
        pb = 1'b0;
        repeat (p / 2) @(negedge clk);
        st = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (p) @(negedge clk);
          d[i] = tx;
        end
        if (parity_en) begin
          repeat (p) @(negedge clk);
          pb = tx;
        end
        repeat (p) @(negedge clk);
        sb1 = tx;
        if (two_stop) begin
          repeat (p) @(negedge clk);
          sb2 = tx;
        end
        if (tx_mon_en) begin
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected_frame: got %02h expected none", d);
          end else begin
            e = exp_tx.pop_front();
            check("tx_start_bit", st, 1'b0);
            check("tx_data", d, e);
            if (parity_en) check("tx_parity", pb, par_of(e, parity_odd));
            check("tx_stop", {sb1, sb2}, 2'b11);
          end
        end
        repeat (p - p / 2 - 1) @(negedge clk);
      end
    end
  end

  // Drains the RX FIFO whenever it shows data and compares against the scoreboard.
  initial begin : rx_monitor
    forever begin
      @(negedge clk);
      if (rx_mon_en && rst === 1'b0 && rx_empty === 1'b0) begin
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected_byte: got %02h expected none", rx_rdata);
        end else begin
          check("rx_data", rx_rdata, exp_rx.pop_front());
        end
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic write_tx(input logic [7:0] d);
    @(negedge clk);
    tx_wr = 1'b1;
    tx_wdata = d;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  // Drives one frame on the rx pad; bad_par / bad_stop corrupt those bits.
  task automatic send_rx(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    int b;
    b = (int'(div_rx) + 1) * OVS;
    if (!(!rx_mon_en && exp_rx.size() >= FIFO_DEPTH)) exp_rx.push_back(d);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (b) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (b) @(negedge clk);
    end
    if (parity_en) begin
      rx_drv = par_of(d, parity_odd) ^ bad_par;
      repeat (b) @(negedge clk);
    end
    rx_drv = ~bad_stop;
    repeat (b) @(negedge clk);
    rx_drv = 1'b1;
    repeat (b) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_rx.size() != 0 || tx_busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got tx_left=%0d rx_left=%0d expected 0", exp_tx.size(), exp_rx.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_no_flags(input string tag);
    check({tag, "_overrun"}, rx_overrun, 1'b0);
    check({tag, "_frame_err"}, rx_frame_err, 1'b0);
    check({tag, "_par_err"}, rx_par_err, 1'b0);
  endtask

  initial begin : stimulus
    int n;
    logic [7:0] d;
    int unsigned nb, nr;
    rst = 1'b1; div_tx = 16'd3; div_rx = 16'd0;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    tx_en = 1'b1; rx_en = 1'b1; tx_wr = 1'b0; tx_wdata = '0;
    rx_rd = 1'b0; err_clr = 1'b0; rx_drv = 1'b1; ext_loop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_tx_full", tx_full, 1'b0);
    check("rst_rx_empty", rx_empty, 1'b1);
    check("rst_rx_rdata", rx_rdata, 8'h00);
    check_no_flags("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1, div_tx=3: one 0xA5 frame keeps tx_busy high for 10 bits x 4 clocks.
    exp_tx.push_back(8'hA5);
    write_tx(8'hA5);
    n = 0;
    while (tx_busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (tx_busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
    check("tx_busy_cycles", n, 40);
    wait_drain(500);

    // External loop tx->rx, 8E1, div_tx=15, div_rx=0.
    ext_loop = 1'b1; parity_en = 1'b1; parity_odd = 1'b0;
    div_tx = 16'd15; div_rx = 16'd0;
    exp_tx.push_back(8'h3C); exp_rx.push_back(8'h3C);
    exp_tx.push_back(8'hFF); exp_rx.push_back(8'hFF);
    write_tx(8'h3C);
    write_tx(8'hFF);
    wait_drain(2000);
    check_no_flags("loop");
    ext_loop = 1'b0;

    // TX FIFO fills with 8 of 9 writes while tx_en=0, then exactly 8 frames go out.
    parity_en = 1'b0; div_tx = 16'd1; tx_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom);
      if (i < FIFO_DEPTH) exp_tx.push_back(d);
      write_tx(d);
      if (i == FIFO_DEPTH - 2) check("tx_full_at_7", tx_full, 1'b0);
      if (i == FIFO_DEPTH - 1) check("tx_full_at_8", tx_full, 1'b1);
    end
    check("tx_full_after_9", tx_full, 1'b1);
    check("tx_idle_while_disabled", tx_busy, 1'b0);
    tx_en = 1'b1;
    wait_drain(2000);
    repeat (20) @(negedge clk);
    check("tx_idle_after_8", tx_busy, 1'b0);
    check("tx_full_drained", tx_full, 1'b0);

    // Nine frames with the RX FIFO not being read: ninth is an overrun.
    div_rx = 16'd1; rx_mon_en = 1'b0;
    for (int i = 0; i < 8; i++) send_rx(8'($urandom), 1'b0, 1'b0);
    check("ovr_not_yet", rx_overrun, 1'b0);
    send_rx(8'($urandom), 1'b0, 1'b0);
    check("ovr_set", rx_overrun, 1'b1);
    check("ovr_head", rx_rdata, exp_rx[0]);
    rx_mon_en = 1'b1;
    wait_drain(500);
    check("ovr_drained_empty", rx_empty, 1'b1);
    @(negedge clk); err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    check("ovr_cleared", rx_overrun, 1'b0);

    // 8O1 frame with wrong parity and low stop bit: both flags, byte still delivered.
    parity_en = 1'b1; parity_odd = 1'b1; div_rx = 16'd0;
    send_rx(8'h5A, 1'b1, 1'b1);
    wait_drain(500);
    check("err_frame_set", rx_frame_err, 1'b1);
    check("err_par_set", rx_par_err, 1'b1);
    @(negedge clk); err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    check("err_frame_clr", rx_frame_err, 1'b0);
    check("err_par_clr", rx_par_err, 1'b0);

    // One-tick low glitch: no byte, no flag.
    parity_en = 1'b0; div_rx = 16'd3;
    @(negedge clk); rx_drv = 1'b0;
    repeat (4) @(negedge clk); rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_rx_empty", rx_empty, 1'b1);
    check_no_flags("glitch");

    // Randomised traffic in both directions with random frame formats.
    for (int it = 0; it < 12; it++) begin
      parity_en = 1'($urandom); parity_odd = 1'($urandom); two_stop = 1'($urandom);
      div_tx = 16'($urandom_range(0, 5)); div_rx = 16'($urandom_range(0, 2));
      nb = $urandom_range(1, 4); nr = $urandom_range(1, 3);
      fork
        begin
          for (int k = 0; k < int'(nb); k++) begin
            d = 8'($urandom);
            exp_tx.push_back(d);
            write_tx(d);
          end
        end
        begin
          for (int k = 0; k < int'(nr); k++) send_rx(8'($urandom), 1'b0, 1'b0);
        end
      join
      wait_drain(5000);
      check_no_flags("rand");
    end

    // Reset in the middle of a TX frame (with a partial RX frame on the line).
    tx_mon_en = 1'b0; two_stop = 1'b0; parity_en = 1'b0; div_tx = 16'd3;
    write_tx(8'h81);
    write_tx(8'h7E);
    rx_drv = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_busy", tx_busy, 1'b0);
    check("rst_mid_rx_empty", rx_empty, 1'b1);
    rst = 1'b0; rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    check("rst_after_tx_idle", tx_busy, 1'b0);
    check("rst_after_tx_line", tx, 1'b1);
    check("rst_after_rx_empty", rx_empty, 1'b1);
    check_no_flags("rst_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
